pulse_capture: RTL and testbench
================================

PULSE_CAPTURE -- requirements
Module: pulse_capture

Interface
REQ-001 The block SHALL have parameter BITS, default 16, giving the width-counter and result width in clock cycles.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port enable, input, 1 bit, which arms capture while high.
REQ-005 The block SHALL have port sig_in, input, 1 bit, the asynchronous pulse to measure.
REQ-006 The block SHALL have port ack, input, 1 bit, a consumer acknowledge that releases a held result.
REQ-007 The block SHALL have port width, output, BITS bits, the measured high time in clk cycles.
REQ-008 The block SHALL have port valid, output, 1 bit, high while width holds an unacknowledged result.
REQ-009 The block SHALL have port overflow, output, 1 bit, set when the held result saturated.
REQ-010 The block SHALL have port busy, output, 1 bit, high in state MEASURE.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchronizer (s1, s2) and then one delay flop (s3); rise = s2 & ~s3, fall = ~s2 & s3.
REQ-012 The FSM SHALL have states IDLE, ARM, MEASURE and HOLD.
REQ-013 IDLE SHALL go to ARM when enable=1 and SHALL otherwise stay in IDLE.
REQ-014 ARM SHALL go to MEASURE on rise and load cnt=1; a pulse already high on entry SHALL produce no rise and SHALL therefore be skipped.
REQ-015 MEASURE SHALL increment cnt once per cycle while s2=1, saturating at 2^BITS-1 and setting an internal sat flag when the saturated value is reached.
REQ-016 MEASURE SHALL, on fall, load width<=cnt and overflow<=sat, set valid=1 on the next cycle, and go to HOLD.
REQ-017 Width SHALL equal the number of cycles s2 was high: a clean N-cycle high pulse on sig_in SHALL give width=N when N<2^BITS-1, and valid SHALL assert 3 cycles after the sig_in falling edge.
REQ-018 HOLD SHALL keep width, overflow and valid=1 stable until ack=1, and SHALL ignore rise/fall in HOLD.
REQ-019 ack=1 in HOLD SHALL clear valid next cycle and go to ARM if enable=1, else to IDLE.
REQ-020 A pulse whose rising edge coincides with the ack cycle SHALL NOT be captured.
REQ-021 ack while valid=0 SHALL have no effect.
REQ-022 enable=0 in ARM or MEASURE SHALL go to IDLE next cycle, discard cnt, and produce no valid.
REQ-023 enable=0 in HOLD SHALL NOT drop the result; the FSM SHALL leave HOLD only on ack.
REQ-024 busy SHALL be 1 exactly while state=MEASURE.
REQ-025 width and overflow SHALL change only on the REQ-016 load or on reset.

Reset
REQ-026 While reset_n=0, state SHALL be IDLE and s1, s2, s3, cnt, sat, width, overflow, valid and busy SHALL be 0, asynchronously.
REQ-027 Reset asserted mid-MEASURE or mid-HOLD SHALL discard all progress.
REQ-028 After reset release, the first capture SHALL require enable=1 and then a fresh rise.

Verification (BITS=8)
REQ-029 enable=1, sig_in low then high 5 cycles -> width=5, overflow=0, valid=1 held until ack, busy high during the pulse.
REQ-030 enable=1, sig_in high 300 cycles -> width=255, overflow=1; after ack, a 3-cycle pulse -> width=3, overflow=0.
REQ-031 sig_in already high when enable rises, falls, then a 7-cycle pulse -> only width=7 is reported.
REQ-032 enable dropped at cycle 4 of a 10-cycle pulse -> valid stays 0 and state returns to IDLE; re-enable, 2-cycle pulse -> width=2.
REQ-033 While valid=1, a 4-cycle pulse with no ack -> width unchanged; ack in the same cycle as a new rise -> that pulse is not captured; the following 6-cycle pulse -> width=6.
REQ-034 reset_n pulsed low mid-MEASURE -> all outputs 0 immediately, and no valid after release until a new full pulse.

Source files
------------

// File: rtl/pulse_capture.sv
// pulse_capture: measures the high time of an asynchronous pulse in clk cycles.
//
// sig_in is synchronised (s1, s2) and delayed once more (s3) for edge detection. Once armed by
// enable, a rising edge starts a saturating count of the synchronised high cycles. On the
// falling edge the count is latched into width and presented with valid until ack.
//
// Ports:
//   clk      - single clock, all state updates on its rising edge
//   reset_n  - asynchronous active-low reset
//   enable   - arms capture while high
//   sig_in   - asynchronous pulse to measure
//   ack      - consumer acknowledge, releases a held result
//   width    - measured high time in clk cycles (saturates at 2^BITS-1)
//   valid    - high while width holds an unacknowledged result
//   overflow - held result saturated
//   busy     - a pulse is currently being measured
module pulse_capture #(
  parameter int unsigned BITS = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            sig_in,
  input  logic            ack,
  output logic [BITS-1:0] width,
  output logic            valid,
  output logic            overflow,
  output logic            busy
);

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StMeasure,
    StHold
  } state_e;

  localparam logic [BITS-1:0] CntOne = BITS'(1);
  localparam logic [BITS-1:0] CntMax = '1;

  state_e          state_q, state_d;
  logic            s1_q, s2_q, s3_q;
  logic [BITS-1:0] cnt_q, cnt_d;
  logic            sat_q, sat_d;
  logic [BITS-1:0] width_q, width_d;
  logic            ovf_q, ovf_d;
  logic            valid_q, valid_d;
  logic            rise, fall;

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      width_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      width_q <= width_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    width_d = width_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StArm;
      end
      StArm: begin
        // Only a fresh rise starts a measurement; a pulse already high on entry is skipped.
        if (!enable) begin
          state_d = StIdle;
        end else if (rise) begin
          state_d = StMeasure;
          cnt_d   = CntOne;
          sat_d   = 1'b0;
        end
      end
      StMeasure: begin
        if (!enable) begin
          state_d = StIdle;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end else if (fall) begin
          state_d = StHold;
          width_d = cnt_q;
          ovf_d   = sat_q;
          valid_d = 1'b1;
        end else if (s2_q && !sat_q) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntMax - 1'b1) sat_d = 1'b1;
        end
      end
      StHold: begin
        // Edges are ignored here; only ack releases the result, regardless of enable.
        if (ack) begin
          valid_d = 1'b0;
          state_d = enable ? StArm : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign width    = width_q;
  assign overflow = ovf_q;
  assign valid    = valid_q;
  assign busy     = (state_q == StMeasure);

endmodule

// File: tb/tb_pulse_capture.sv
// Self-checking bench for pulse_capture (BITS=8): a table of pulse lengths with expected
// results, directed multi-cycle sequences, and random pulses checked against a simple model.
module tb_pulse_capture;

  localparam int unsigned BITS = 8;
  localparam int MaxCnt = (1 << BITS) - 1;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            enable;
  logic            sig_in;
  logic            ack;
  logic [BITS-1:0] width;
  logic            valid;
  logic            overflow;
  logic            busy;

  int total = 0;
  int bad   = 0;

  pulse_capture #(.BITS(BITS)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .sig_in   (sig_in),
    .ack      (ack),
    .width    (width),
    .valid    (valid),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int exp_w;
    int exp_o;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance n clock cycles; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: width is the pulse length clipped to the counter maximum; overflow when clipped
  // value is reached.
  function automatic void ref_model(input int n, output int w, output int o);
    w = (n >= MaxCnt) ? MaxCnt : n;
    o = (n >= MaxCnt) ? 1 : 0;
  endfunction

  // Drive an n-cycle pulse from the armed state, check latency/result, optionally inject a
  // pulse during hold that must be ignored, then acknowledge.
  task automatic capture(input string name, input int n, input int ew, input int eo,
                         input int noise_len);
    sig_in = 1'b1;
    cyc(n);
    sig_in = 1'b0;
    cyc(2);
    check({name, " valid before latency"}, valid, 0);
    check({name, " busy while measuring"}, busy, 1);
    cyc(1);
    check({name, " valid at latency"}, valid, 1);
    check({name, " width"}, width, ew);
    check({name, " overflow"}, overflow, eo);
    check({name, " busy after fall"}, busy, 0);
    if (noise_len > 0) begin
      sig_in = 1'b1;
      cyc(noise_len);
      sig_in = 1'b0;
      cyc(5);
      check({name, " width held over noise"}, width, ew);
      check({name, " valid held over noise"}, valid, 1);
    end
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    check({name, " valid cleared by ack"}, valid, 0);
  endtask

  initial begin
    vecs[0] = '{len: 5,   exp_w: 5,   exp_o: 0};
    vecs[1] = '{len: 300, exp_w: 255, exp_o: 1};
    vecs[2] = '{len: 3,   exp_w: 3,   exp_o: 0};
    vecs[3] = '{len: 1,   exp_w: 1,   exp_o: 0};
    vecs[4] = '{len: 254, exp_w: 254, exp_o: 0};
    vecs[5] = '{len: 255, exp_w: 255, exp_o: 1};
    vecs[6] = '{len: 256, exp_w: 255, exp_o: 1};
    vecs[7] = '{len: 2,   exp_w: 2,   exp_o: 0};

    reset_n = 1'b0;
    enable  = 1'b0;
    sig_in  = 1'b0;
    ack     = 1'b0;
    cyc(2);
    check("reset width", width, 0);
    check("reset valid", valid, 0);
    check("reset overflow", overflow, 0);
    check("reset busy", busy, 0);
    reset_n = 1'b1;

    // Without enable nothing is captured.
    sig_in = 1'b1;
    cyc(4);
    check("disabled busy", busy, 0);
    sig_in = 1'b0;
    cyc(6);
    check("disabled valid", valid, 0);

    enable = 1'b1;
    cyc(1);
    foreach (vecs[i]) begin
      capture($sformatf("vec%0d len=%0d", i, vecs[i].len), vecs[i].len, vecs[i].exp_w,
              vecs[i].exp_o, 0);
    end

    // Pulse already high when enable rises is skipped.
    enable = 1'b0;
    cyc(1);
    sig_in = 1'b1;
    cyc(4);
    enable = 1'b1;
    cyc(5);
    check("prehigh busy", busy, 0);
    sig_in = 1'b0;
    cyc(6);
    check("prehigh valid", valid, 0);
    capture("prehigh then 7", 7, 7, 0, 0);

    // enable dropped mid-measurement discards the pulse.
    sig_in = 1'b1;
    cyc(4);
    check("drop busy before", busy, 1);
    enable = 1'b0;
    cyc(1);
    check("drop busy after", busy, 0);
    cyc(5);
    sig_in = 1'b0;
    cyc(6);
    check("drop valid", valid, 0);
    enable = 1'b1;
    cyc(1);
    capture("reenable 2", 2, 2, 0, 0);

    // Held result survives new pulses and enable=0; ack coinciding with rise skips that pulse.
    sig_in = 1'b1;
    cyc(5);
    sig_in = 1'b0;
    cyc(3);
    check("hold first valid", valid, 1);
    check("hold first width", width, 5);
    sig_in = 1'b1;
    cyc(4);
    sig_in = 1'b0;
    cyc(6);
    check("hold ignore width", width, 5);
    check("hold ignore valid", valid, 1);
    check("hold ignore busy", busy, 0);
    enable = 1'b0;
    cyc(3);
    check("hold enable0 valid", valid, 1);
    check("hold enable0 width", width, 5);
    enable = 1'b1;
    sig_in = 1'b1;
    cyc(2);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    check("ack-rise valid cleared", valid, 0);
    cyc(3);
    check("ack-rise busy", busy, 0);
    sig_in = 1'b0;
    cyc(6);
    check("ack-rise not captured", valid, 0);
    capture("after ack 6", 6, 6, 0, 0);

    // ack without a held result has no effect.
    ack = 1'b1;
    cyc(2);
    ack = 1'b0;
    check("stray ack valid", valid, 0);
    capture("after stray ack 3", 3, 3, 0, 0);

    // Reset mid-measurement clears everything at once.
    capture("pre-reset sat", 256, 255, 1, 0);
    sig_in = 1'b1;
    cyc(4);
    check("mid busy", busy, 1);
    reset_n = 1'b0;
    sig_in  = 1'b0;
    #1;
    check("async reset width", width, 0);
    check("async reset overflow", overflow, 0);
    check("async reset valid", valid, 0);
    check("async reset busy", busy, 0);
    cyc(2);
    reset_n = 1'b1;
    cyc(8);
    check("post-reset valid", valid, 0);
    check("post-reset busy", busy, 0);
    capture("post-reset 4", 4, 4, 0, 0);

    // Random pulses against the reference model.
    for (int k = 0; k < 24; k++) begin
      int n, ew, eo, noise;
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(200, 300))
                                      : int'($urandom_range(1, 40));
      noise = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
      ref_model(n, ew, eo);
      cyc(int'($urandom_range(0, 4)));
      capture($sformatf("rand%0d len=%0d", k, n), n, ew, eo, noise);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
